// File: rtl/fifo_pkg.sv
// Shared definitions for the 8-entry FIFO and its reader-side master.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package fifo_pkg;

    localparam int FIFO_DEPTH = 8;
    localparam int FIFO_CNT_W = 4;

    // Internal state codes of the FIFO itself; a simultaneous rd_en and
    // wr_en lands it in NO_OP, which is why the master never collides.
    typedef enum logic [2:0] {
        INIT     = 3'b000,
        READ     = 3'b001,
        WRITE    = 3'b010,
        RD_ERROR = 3'b011,
        WR_ERROR = 3'b100,
        NO_OP    = 3'b101
    } fifo_state_t;

    // Reader-master control states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        BACKOFF = 2'd2
    } mst_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry in-order holding buffer between the FIFO response and the downstream stream.
// Latency: a pushed word is visible at the head the cycle after the push.
// Backpressure: head held stable until popped; a push while full with no pop is ignored.
//
// Ports: clk, reset_n (async active-low); i_push/i_push_dat write side;
//        i_pop removes the head; o_occ occupancy 0..2; o_head_dat oldest word.
module fifo_rd_skid #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_dat,
    input  logic              i_pop,
    output logic [1:0]        o_occ,
    output logic [DATA_W-1:0] o_head_dat
);

    logic [DATA_W-1:0] r_ent0;   // head
    logic [DATA_W-1:0] r_ent1;   // second-oldest
    logic [1:0]        r_occ;
    logic              w_pop;

    assign w_pop      = i_pop & (r_occ != 2'd0);
    assign o_occ      = r_occ;
    assign o_head_dat = r_ent0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ent0 <= '0;
            r_ent1 <= '0;
            r_occ  <= 2'd0;
        end else begin
            case ({i_push, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_ent0 <= i_push_dat;
                        r_occ  <= 2'd1;
                    end else if (r_occ == 2'd1) begin
                        r_ent1 <= i_push_dat;
                        r_occ  <= 2'd2;
                    end
                end
                2'b01: begin
                    r_ent0 <= r_ent1;
                    r_occ  <= r_occ - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the new word goes behind whatever remains.
                    if (r_occ == 2'd1) begin
                        r_ent0 <= i_push_dat;
                    end else begin
                        r_ent0 <= r_ent1;
                        r_ent1 <= i_push_dat;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_rd_master.sv
// Reader-side master: issues FIFO reads and streams the words out on valid/ready.
// Latency: rd_en in cycle N, ack in N+1, m_valid in N+2; up to one word per cycle.
// Backpressure: reads stop once held words plus the read in flight fill the 2-entry skid.
//
// Ports: clk, reset_n (async active-low); enable; FIFO side fifo_count,
//        fifo_wr_en, fifo_rd_ack, fifo_rd_err, fifo_dout, fifo_rd_en;
//        stream m_valid/m_data/m_ready; status err_count, proto_err, busy.
module fifo_rd_master
    import fifo_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int SKID_DEPTH  = 2,
    parameter int BACKOFF_CYC = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [FIFO_CNT_W-1:0] fifo_count,
    input  logic                  fifo_wr_en,
    input  logic                  fifo_rd_ack,
    input  logic                  fifo_rd_err,
    input  logic [DATA_W-1:0]     fifo_dout,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    output logic [DATA_W-1:0]     m_data,
    input  logic                  m_ready,
    output logic [7:0]            err_count,
    output logic                  proto_err,
    output logic                  busy
);

    mst_state_t r_state;
    mst_state_t w_state_nxt;
    logic       r_inflight;
    logic [3:0] r_bo_cnt;
    logic [3:0] w_bo_cnt_nxt;
    logic [7:0] r_err_count;
    logic       r_proto_err;

    logic       w_rd_en;
    logic [1:0] w_occ;
    logic [1:0] w_occ_eff;
    logic       w_pop;
    logic       w_cnt_ok;
    logic       w_room_ok;
    logic       w_skid_full;

    logic       w_resp_ack;
    logic       w_resp_err;
    logic       w_missing;
    logic       w_unsol;
    logic       w_both;
    logic       w_overflow;
    logic       w_push;
    logic       w_proto_evt;

    // ------------------------------------------------------------------
    // Response classification; a response is only legitimate in the
    // cycle after we issued a read.
    // ------------------------------------------------------------------
    assign w_resp_ack  = r_inflight & fifo_rd_ack & ~fifo_rd_err;
    assign w_resp_err  = r_inflight & fifo_rd_err;   // ack+err counts as err
    assign w_missing   = r_inflight & ~fifo_rd_ack & ~fifo_rd_err;
    assign w_unsol     = ~r_inflight & (fifo_rd_ack | fifo_rd_err);
    assign w_both      = r_inflight & fifo_rd_ack & fifo_rd_err;

    assign w_pop       = m_valid & m_ready;
    assign w_skid_full = (w_occ == 2'(SKID_DEPTH));
    assign w_overflow  = w_resp_ack & w_skid_full & ~w_pop;
    assign w_push      = w_resp_ack & ~w_overflow;
    assign w_proto_evt = w_missing | w_unsol | w_both | w_overflow;

    // ------------------------------------------------------------------
    // Issue rule. fifo_count still includes the word of a read whose ack
    // is on the wire now, so one in-flight read must be subtracted. A word
    // leaving the skid this cycle frees its slot for the new read.
    // ------------------------------------------------------------------
    assign w_cnt_ok  = (fifo_count > {{(FIFO_CNT_W-1){1'b0}}, r_inflight});
    assign w_occ_eff = w_occ - {1'b0, w_pop};
    assign w_room_ok = (({1'b0, w_occ_eff} + {2'b00, r_inflight}) < 3'(SKID_DEPTH));

    always_comb begin
        w_state_nxt  = r_state;
        w_bo_cnt_nxt = r_bo_cnt;
        w_rd_en      = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable) w_state_nxt = RUN;
            end
            RUN: begin
                w_rd_en = enable & ~fifo_wr_en & w_cnt_ok & w_room_ok;
                if (w_resp_err) begin
                    w_state_nxt  = BACKOFF;
                    w_bo_cnt_nxt = BACKOFF_CYC[3:0];
                end else if (!enable && !r_inflight) begin
                    w_state_nxt = IDLE;
                end
            end
            BACKOFF: begin
                // Stays here for exactly BACKOFF_CYC cycles.
                w_bo_cnt_nxt = r_bo_cnt - 4'd1;
                if (r_bo_cnt <= 4'd1) begin
                    w_bo_cnt_nxt = 4'd0;
                    w_state_nxt  = enable ? RUN : IDLE;
                end
            end
            default: begin
                w_state_nxt  = IDLE;
                w_bo_cnt_nxt = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_bo_cnt    <= 4'd0;
            r_inflight  <= 1'b0;
            r_err_count <= 8'd0;
            r_proto_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_bo_cnt   <= w_bo_cnt_nxt;
            r_inflight <= w_rd_en;
            if (w_resp_err)  r_err_count <= sat_inc8(r_err_count);
            if (w_proto_evt) r_proto_err <= 1'b1;
        end
    end

    fifo_rd_skid #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_push     (w_push),
        .i_push_dat (fifo_dout),
        .i_pop      (w_pop),
        .o_occ      (w_occ),
        .o_head_dat (m_data)
    );

    assign fifo_rd_en = w_rd_en;
    assign m_valid    = (w_occ != 2'd0);
    assign busy       = r_inflight | m_valid;
    assign err_count  = r_err_count;
    assign proto_err  = r_proto_err;

endmodule

// File: tb/tb_fifo_rd_master.sv
// Directed bench for fifo_rd_master with a cycle-stepped FIFO responder.
// Latency: responses are driven 1 cycle after a sampled rd_en.
// Backpressure: m_ready driven per scenario.
module tb_fifo_rd_master;

    logic       clk;
    logic       reset_n;
    logic       enable;
    logic [3:0] fifo_count;
    logic       fifo_wr_en;
    logic       fifo_rd_ack;
    logic       fifo_rd_err;
    logic [7:0] fifo_dout;
    logic       fifo_rd_en;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ready;
    logic [7:0] err_count;
    logic       proto_err;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic       auto_resp;
    logic       err_mode;
    logic [7:0] data_q[$];

    fifo_rd_master #(
        .DATA_W      (8),
        .SKID_DEPTH  (2),
        .BACKOFF_CYC (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .fifo_count  (fifo_count),
        .fifo_wr_en  (fifo_wr_en),
        .fifo_rd_ack (fifo_rd_ack),
        .fifo_rd_err (fifo_rd_err),
        .fifo_dout   (fifo_dout),
        .fifo_rd_en  (fifo_rd_en),
        .m_valid     (m_valid),
        .m_data      (m_data),
        .m_ready     (m_ready),
        .err_count   (err_count),
        .proto_err   (proto_err),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; the FIFO model answers last cycle's rd_en and
    // retires a word from its count one cycle after the ack.
    task automatic cyc();
        logic p_rd;
        logic p_ack;
        p_rd  = fifo_rd_en;
        p_ack = fifo_rd_ack;
        @(posedge clk);
        #1;
        if (auto_resp) begin
            fifo_rd_ack = p_rd & ~err_mode;
            fifo_rd_err = p_rd & err_mode;
            fifo_dout   = 8'h00;
            if (p_rd && !err_mode && data_q.size() > 0) fifo_dout = data_q.pop_front();
            if (p_ack && fifo_count > 4'd0) fifo_count = fifo_count - 4'd1;
        end
        #1;
    endtask

    task automatic apply_reset();
        reset_n     = 1'b0;
        enable      = 1'b0;
        fifo_count  = 4'd0;
        fifo_wr_en  = 1'b0;
        fifo_rd_ack = 1'b0;
        fifo_rd_err = 1'b0;
        fifo_dout   = 8'h00;
        m_ready     = 1'b0;
        auto_resp   = 1'b1;
        err_mode    = 1'b0;
        data_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // Reset, enable, and step past the IDLE cycle so the master is in RUN.
    task automatic start_run();
        apply_reset();
        enable = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; enable = 1'b1; fifo_count = 4'd8; m_ready = 1'b1;
        #1;
        n_tests++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en got=%b exp=0", fifo_rd_en); end
        @(posedge clk); #1;
        n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
        n_tests++; if (m_data !== 8'h00) begin n_fail++; $display("FAIL reset_m_data got=%h exp=00", m_data); end
        n_tests++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL reset_err_count got=%0d exp=0", err_count); end
        n_tests++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL reset_proto_err got=%b exp=0", proto_err); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        apply_reset();
        enable = 1'b1;
        #1;
        n_tests++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL idle_no_rd got=%b exp=0", fifo_rd_en); end
    endtask

    task automatic test_stream();
        start_run();
        data_q = '{8'hAA, 8'hBB, 8'hCC};
        fifo_count = 4'd3; m_ready = 1'b1;
        #1;
        n_tests++; if (fifo_rd_en !== 1'b1) begin n_fail++; $display("FAIL stream_rd1 got=%b exp=1", fifo_rd_en); end
        cyc(); #1;
        n_tests++; if (fifo_rd_en !== 1'b1) begin n_fail++; $display("FAIL stream_rd2 got=%b exp=1", fifo_rd_en); end
        n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL stream_early_valid got=%b exp=0", m_valid); end
        cyc(); #1;
        n_tests++; if (fifo_rd_en !== 1'b1) begin n_fail++; $display("FAIL stream_rd3 got=%b exp=1", fifo_rd_en); end
        n_tests++; if ({m_valid, m_data} !== {1'b1, 8'hAA}) begin n_fail++; $display("FAIL stream_w0 got=%b/%h exp=1/aa", m_valid, m_data); end
        cyc(); #1;
        n_tests++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL stream_rd4 got=%b exp=0", fifo_rd_en); end
        n_tests++; if ({m_valid, m_data} !== {1'b1, 8'hBB}) begin n_fail++; $display("FAIL stream_w1 got=%b/%h exp=1/bb", m_valid, m_data); end
        cyc(); #1;
        n_tests++; if ({m_valid, m_data} !== {1'b1, 8'hCC}) begin n_fail++; $display("FAIL stream_w2 got=%b/%h exp=1/cc", m_valid, m_data); end
        n_tests++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL stream_rd5 got=%b exp=0", fifo_rd_en); end
        cyc(); #1;
        n_tests++; if ({m_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL stream_drained got=%b%b exp=00", m_valid, busy); end
        n_tests++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL stream_err_count got=%0d exp=0", err_count); end
    endtask

    task automatic test_collision();
        start_run();
        fifo_count = 4'd5; m_ready = 1'b1; fifo_wr_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) cyc();
            #1;
            n_tests++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL collision_cyc%0d got=%b exp=0", i, fifo_rd_en); end
        end
        cyc();
        fifo_wr_en = 1'b0;
        #1;
        n_tests++; if (fifo_rd_en !== 1'b1) begin n_fail++; $display("FAIL collision_release got=%b exp=1", fifo_rd_en); end
    endtask

    task automatic test_backpressure();
        start_run();
        data_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        fifo_count = 4'd8; m_ready = 1'b0;
        #1;
        n_tests++; if (fifo_rd_en !== 1'b1) begin n_fail++; $display("FAIL bp_rd1 got=%b exp=1", fifo_rd_en); end
        cyc(); #1;
        n_tests++; if (fifo_rd_en !== 1'b1) begin n_fail++; $display("FAIL bp_rd2 got=%b exp=1", fifo_rd_en); end
        for (int i = 0; i < 3; i++) begin
            cyc(); #1;
            n_tests++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL bp_hold_rd%0d got=%b exp=0", i, fifo_rd_en); end
            n_tests++; if ({m_valid, m_data} !== {1'b1, 8'h11}) begin n_fail++; $display("FAIL bp_hold_dat%0d got=%b/%h exp=1/11", i, m_valid, m_data); end
        end
        cyc();
        m_ready = 1'b1;
        #1;
        n_tests++; if (fifo_rd_en !== 1'b1) begin n_fail++; $display("FAIL bp_pop_rd got=%b exp=1", fifo_rd_en); end
        n_tests++; if (m_data !== 8'h11) begin n_fail++; $display("FAIL bp_pop_dat got=%h exp=11", m_data); end
        cyc();
        m_ready = 1'b0;
        #1;
        n_tests++; if ({fifo_rd_en, m_data} !== {1'b0, 8'h22}) begin n_fail++; $display("FAIL bp_after1 got=%b/%h exp=0/22", fifo_rd_en, m_data); end
        cyc(); #1;
        n_tests++; if ({fifo_rd_en, m_valid, m_data} !== {2'b01, 8'h22}) begin n_fail++; $display("FAIL bp_after2 got=%b%b/%h exp=01/22", fifo_rd_en, m_valid, m_data); end
    endtask

    task automatic test_empty_error();
        start_run();
        err_mode = 1'b1; fifo_count = 4'd1; m_ready = 1'b1;
        #1;
        n_tests++; if (fifo_rd_en !== 1'b1) begin n_fail++; $display("FAIL err_first_rd got=%b exp=1", fifo_rd_en); end
        cyc(); #1;
        n_tests++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL err_count_pre got=%0d exp=0", err_count); end
        for (int i = 0; i < 4; i++) begin
            cyc(); #1;
            n_tests++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL err_backoff%0d got=%b exp=0", i, fifo_rd_en); end
            if (i == 0) begin
                n_tests++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL err_count_one got=%0d exp=1", err_count); end
            end
        end
        cyc(); #1;
        n_tests++; if (fifo_rd_en !== 1'b1) begin n_fail++; $display("FAIL err_resume got=%b exp=1", fifo_rd_en); end
        // Roughly one error per 6 cycles: well over 256 errors.
        repeat (1700) cyc();
        #1;
        n_tests++; if (err_count !== 8'd255) begin n_fail++; $display("FAIL err_saturate got=%0d exp=255", err_count); end
        n_tests++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL err_no_proto got=%b exp=0", proto_err); end
    endtask

    task automatic test_proto_missing();
        start_run();
        auto_resp = 1'b0; fifo_count = 4'd1;
        #1;
        n_tests++; if (fifo_rd_en !== 1'b1) begin n_fail++; $display("FAIL miss_rd got=%b exp=1", fifo_rd_en); end
        cyc(); #1;
        n_tests++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL miss_early got=%b exp=0", proto_err); end
        cyc();
        enable = 1'b0;
        #1;
        n_tests++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL miss_set got=%b exp=1", proto_err); end
        repeat (5) cyc();
        #1;
        n_tests++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL miss_sticky got=%b exp=1", proto_err); end
    endtask

    task automatic test_proto_unsolicited();
        start_run();
        auto_resp = 1'b0; enable = 1'b0;
        fifo_rd_ack = 1'b1; fifo_dout = 8'h77;
        #1;
        n_tests++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL unsol_pre got=%b exp=0", proto_err); end
        cyc();
        fifo_rd_ack = 1'b0;
        #1;
        n_tests++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL unsol_proto got=%b exp=1", proto_err); end
        n_tests++; if ({m_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL unsol_valid got=%b%b exp=00", m_valid, busy); end
    endtask

    task automatic test_reset_inflight();
        start_run();
        auto_resp = 1'b0; fifo_count = 4'd1;
        #1;
        n_tests++; if (fifo_rd_en !== 1'b1) begin n_fail++; $display("FAIL rstin_rd got=%b exp=1", fifo_rd_en); end
        cyc(); #1;
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstin_busy got=%b exp=1", busy); end
        reset_n = 1'b0;
        #1;
        n_tests++; if ({fifo_rd_en, m_valid, busy, proto_err} !== 4'b0000) begin n_fail++; $display("FAIL rstin_async got=%b%b%b%b exp=0000", fifo_rd_en, m_valid, busy, proto_err); end
        n_tests++; if ({err_count, m_data} !== 16'h0000) begin n_fail++; $display("FAIL rstin_regs got=%h/%h exp=00/00", err_count, m_data); end
        #1;
        reset_n = 1'b1; enable = 1'b0;
        fifo_rd_ack = 1'b1; fifo_dout = 8'h5A;
        #1;
        cyc();
        fifo_rd_ack = 1'b0;
        #1;
        n_tests++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL rstin_late_ack got=%b exp=1", proto_err); end
        n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rstin_no_valid got=%b exp=0", m_valid); end
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b0; fifo_count = 4'd0; fifo_wr_en = 1'b0;
        fifo_rd_ack = 1'b0; fifo_rd_err = 1'b0; fifo_dout = 8'h00; m_ready = 1'b0;
        auto_resp = 1'b1; err_mode = 1'b0;
        test_reset();
        test_stream();
        test_collision();
        test_backpressure();
        test_empty_error();
        test_proto_missing();
        test_proto_unsolicited();
        test_reset_inflight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_rd_master.md
Name: fifo_rd_master

Overview:
- Reader-side master for the team's 8-entry FIFO. It issues rd_en, consumes the FIFO's rd_ack/rd_err responses and d_out, and presents the words on a downstream valid/ready stream.
- Never collides with the writer: simultaneous rd_en and wr_en drives the FIFO to NO_OP.
- Sits between the FIFO read port and any downstream consumer.

Parameters:
- DATA_W, 8, width of FIFO data word and m_data.
- SKID_DEPTH, 2, downstream holding entries (fixed 2; other values unsupported).
- BACKOFF_CYC, 4, idle cycles after a rd_err before the next rd_en (1..15).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  1 = master may issue reads.
- fifo_count  in  4  FIFO data_count (0..8).
- fifo_wr_en  in  1  writer's wr_en this cycle (arbitration view).
- fifo_rd_ack  in  1  FIFO read acknowledge.
- fifo_rd_err  in  1  FIFO read error (read while empty).
- fifo_dout  in  DATA_W  FIFO read data, valid when fifo_rd_ack=1.
- fifo_rd_en  out  1  read request to FIFO.
- m_valid  out  1  downstream data valid.
- m_data  out  DATA_W  downstream data.
- m_ready  in  1  downstream accept.
- err_count  out  8  saturating count of rd_err responses.
- proto_err  out  1  sticky: expected response missing or unsolicited response.
- busy  out  1  read in flight or skid non-empty.

Behaviour:
- Reset (async, reset_n=0): fifo_rd_en=0, m_valid=0, m_data=0, err_count=0, proto_err=0, busy=0, state=IDLE, skid empty, inflight=0, backoff counter=0. Reset mid-transfer drops any in-flight response; the next response after release sets proto_err.
- FIFO protocol, fixed: response exactly 1 cycle after fifo_rd_en=1. Either fifo_rd_ack (fifo_dout valid) or fifo_rd_err. fifo_count reflects a read 1 cycle after its ack.
- inflight: 1-bit register, set to fifo_rd_en each cycle.
- States:
  - IDLE: fifo_rd_en=0. IDLE->RUN when enable=1.
  - RUN: fifo_rd_en is combinational from registered state/counters and current inputs. Asserted iff all hold:
    - enable=1
    - fifo_wr_en=0
    - fifo_count > inflight (the unsettled count must not underflow)
    - skid_occupancy + inflight < 2 (an accept this cycle does not count)
  - RUN->IDLE when enable=0 and inflight=0. The skid still drains in IDLE.
  - RUN->BACKOFF on fifo_rd_err (response cycle). Load the counter with BACKOFF_CYC.
  - BACKOFF: fifo_rd_en=0. Decrement the counter each cycle. At 0 go to RUN if enable=1, else IDLE.
- Response handling, all states:
  - inflight=1 with rd_ack: push fifo_dout into skid.
  - inflight=1 with rd_err: err_count+1, saturating at 255.
  - inflight=1 with neither: proto_err<=1.
  - inflight=0 with ack or err: proto_err<=1, data discarded.
  - ack and err together: treat as err, proto_err<=1.
- Skid: 2-entry in-order buffer. m_valid = occupancy>0. m_data = head entry.
  - Pop on m_valid&m_ready.
  - Push and pop in the same cycle keeps occupancy unchanged.
  - Push while full cannot occur by the issue rule; if it does, proto_err<=1 and drop the word.
  - m_data is held stable while m_valid=1 and m_ready=0.
- Throughput: back-to-back rd_en is allowed (1 word/cycle) when fifo_count ≥2 and m_ready=1.
- First-word latency: rd_en cycle N, ack N+1, m_valid N+2.
- busy = inflight | (occupancy>0).

Decomposition:
- Shared package fifo_pkg:
  - FIFO state codes: INIT=000, READ=001, WRITE=010, RD_ERROR=011, WR_ERROR=100, NO_OP=101.
  - FIFO_DEPTH=8, FIFO_CNT_W=4.
  - Master state codes: IDLE, RUN, BACKOFF.
- One sub-module, fifo_rd_skid: the 2-entry buffer with push/pop/occupancy, DATA_W parameter.

Test Plan:
- Stream: fifo_count=3, m_ready=1, enable=1, FIFO model acks AA,BB,CC → rd_en 3 consecutive cycles; m_data AA,BB,CC on consecutive cycles starting 2 cycles after the first rd_en; err_count=0.
- Collision: fifo_wr_en=1 for 3 cycles with fifo_count=5 → fifo_rd_en=0 for those 3 cycles; first rd_en the cycle fifo_wr_en drops.
- Backpressure: m_ready=0, fifo_count=8 → exactly 2 reads issued, m_valid=1 with m_data stable, no further rd_en. m_ready=1 for 1 cycle → one pop, one new rd_en the same cycle.
- Empty error: model returns rd_err to a read → err_count=1, no rd_en for 4 cycles, then reads resume. 256 errors → err_count stays 255.
- Protocol: no response after a rd_en → proto_err=1 next cycle, sticky. An unsolicited rd_ack → proto_err=1 and m_valid unaffected.
- Reset: reset_n low during an in-flight read → all outputs 0 immediately (async). Ack arriving after release → proto_err=1, no m_valid.
